// File: rtl/rv_mem_arb_pkg.sv
// rv_mem_arbiter shared types
// owner FSM encoding, read-return tag, counter width
package rv_mem_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    DPRI    = 1'b0,
    FORCE_I = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic rd_if;
    logic rd_dm;
  } t_rd_tag;

endpackage

// File: rtl/rv_mem_arb_starve.sv
// rv_mem_arbiter starvation guard
// counts lost fetch cycles, flips ownership to fetch at the limit
module rv_mem_arb_starve
  import rv_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT =
    STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] ONE =
    STARVE_CNT_W'(1);

  t_arb_state                state_q;
  t_arb_state                state_d;
  logic [STARVE_CNT_W-1:0]   cnt_q;
  logic [STARVE_CNT_W-1:0]   cnt_d;
  logic                      if_lost;

  assign if_lost = if_req & ~if_gnt;

  // saturating count of consecutive lost fetch cycles
  always_comb begin
    cnt_d = '0;
    if (if_lost) begin
      if (cnt_q >= LIMIT)
        cnt_d = LIMIT;
      else
        cnt_d = cnt_q + ONE;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // owner state register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= DPRI;
    else
      state_q <= state_d;
  end

  // owner next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DPRI: begin
        if (cnt_d == LIMIT)
          state_d = FORCE_I;
      end
      FORCE_I: begin
        if (if_gnt || !if_req)
          state_d = DPRI;
      end
      default: state_d = DPRI;
    endcase
  end

  // owner outputs
  always_comb begin
    force_if = 1'b0;
    unique case (state_q)
      DPRI:    force_if = 1'b0;
      FORCE_I: force_if = 1'b1;
      default: force_if = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: one single-port RAM shared by fetch and data
// data has priority; the starvation guard guarantees fetch progress
module rv_mem_arbiter
  import rv_mem_arb_pkg::*;
#(
  parameter int MEM_SIZE_WORDS = 256,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_Q100H,
  input  logic [31:0] if_addr_Q100H,
  output logic        if_gnt_Q100H,
  output logic        if_rvalid_Q101H,
  output logic [31:0] if_rdata_Q101H,

  input  logic        dm_req_Q103H,
  input  logic [31:0] dm_addr_Q103H,
  input  logic        dm_wr_en_Q103H,
  input  logic [31:0] dm_wr_data_Q103H,
  input  logic [3:0]  dm_byte_en_Q103H,
  output logic        dm_gnt_Q103H,
  output logic        dm_rvalid_Q104H,
  output logic [31:0] dm_rdata_Q104H,

  output logic        stall_if,
  output logic        stall_mem,

  output logic [$clog2(MEM_SIZE_WORDS)-1:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rd_data
);

  localparam int AW = $clog2(MEM_SIZE_WORDS);

  logic          run;
  logic          force_if;
  logic          dm_write;
  logic [AW-1:0] if_word;
  logic [AW-1:0] dm_word;
  logic [AW-1:0] addr_q;
  t_rd_tag       tag_d;
  t_rd_tag       tag_q;
  logic          unused_addr_bits;

  assign run     = ~rst;
  assign if_word = if_addr_Q100H[AW+1:2];
  assign dm_word = dm_addr_Q103H[AW+1:2];

  // upper bits wrap away, lane bits are the requester's concern
  assign unused_addr_bits = ^{
    if_addr_Q100H[31:AW+2], if_addr_Q100H[1:0],
    dm_addr_Q103H[31:AW+2], dm_addr_Q103H[1:0]
  };

  rv_mem_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req_Q100H),
    .if_gnt   (if_gnt_Q100H),
    .force_if (force_if)
  );

  // grant from requests and registered owner only
  always_comb begin
    if_gnt_Q100H = run & if_req_Q100H
                 & (~dm_req_Q103H | force_if);
    dm_gnt_Q103H = run & dm_req_Q103H
                 & ~(if_req_Q100H & force_if);
  end

  // stalls: requested this cycle but lost
  always_comb begin
    stall_if  = run & if_req_Q100H & ~if_gnt_Q100H;
    stall_mem = run & dm_req_Q103H & ~dm_gnt_Q103H;
  end

  // RAM drive; address parks on last value when idle
  always_comb begin
    dm_write    = dm_gnt_Q103H & dm_wr_en_Q103H;
    mem_addr    = addr_q;
    mem_wr_en   = dm_write;
    mem_wr_data = '0;
    mem_byte_en = '0;
    if (dm_gnt_Q103H)
      mem_addr = dm_word;
    else if (if_gnt_Q100H)
      mem_addr = if_word;
    if (dm_write) begin
      mem_wr_data = dm_wr_data_Q103H;
      mem_byte_en = dm_byte_en_Q103H;
    end
  end

  // last driven RAM address
  always_ff @(posedge clk) begin
    if (rst)
      addr_q <= '0;
    else
      addr_q <= mem_addr;
  end

  // read tag for next-cycle return; writes set none
  always_comb begin
    tag_d.rd_if = if_gnt_Q100H;
    tag_d.rd_dm = dm_gnt_Q103H & ~dm_wr_en_Q103H;
  end

  // read tag register
  always_ff @(posedge clk) begin
    if (rst)
      tag_q <= '0;
    else
      tag_q <= tag_d;
  end

  // route RAM data to the owner; reset kills in-flight returns
  always_comb begin
    if_rvalid_Q101H = run & tag_q.rd_if;
    dm_rvalid_Q104H = run & tag_q.rd_dm;
    if_rdata_Q101H  = '0;
    dm_rdata_Q104H  = '0;
    if (if_rvalid_Q101H)
      if_rdata_Q101H = mem_rd_data;
    if (dm_rvalid_Q104H)
      dm_rdata_Q104H = mem_rd_data;
  end

  a_one_grant: assert property (
    @(posedge clk) !(if_gnt_Q100H && dm_gnt_Q103H)
  );

  a_limit_range: assert property (
    @(posedge clk) (STARVE_LIMIT >= 1 && STARVE_LIMIT <= 15)
  );

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// rv_mem_arbiter bench: vector table plus reset/starvation sequences
// second instance with STARVE_LIMIT=1 covers the minimum limit
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_wr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;

  logic        if_gnt, if_rv, dm_gnt, dm_rv;
  logic [31:0] if_rd, dm_rd;
  logic        st_if, st_mem;
  logic [7:0]  m_addr;
  logic        m_wr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;

  logic        g1_if, g1_dm, rv1_if, rv1_dm;
  logic [31:0] rd1_if, rd1_dm;
  logic        s1_if, s1_mem;
  logic [7:0]  m1_addr;
  logic        m1_wr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_be;
  logic [31:0] zero32;

  logic [31:0] ram [256];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  assign zero32 = 32'h0;

  rv_mem_arbiter #(
    .MEM_SIZE_WORDS (256),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req_Q100H     (if_req),
    .if_addr_Q100H    (if_addr),
    .if_gnt_Q100H     (if_gnt),
    .if_rvalid_Q101H  (if_rv),
    .if_rdata_Q101H   (if_rd),
    .dm_req_Q103H     (dm_req),
    .dm_addr_Q103H    (dm_addr),
    .dm_wr_en_Q103H   (dm_wr),
    .dm_wr_data_Q103H (dm_wdata),
    .dm_byte_en_Q103H (dm_be),
    .dm_gnt_Q103H     (dm_gnt),
    .dm_rvalid_Q104H  (dm_rv),
    .dm_rdata_Q104H   (dm_rd),
    .stall_if         (st_if),
    .stall_mem        (st_mem),
    .mem_addr         (m_addr),
    .mem_wr_en        (m_wr),
    .mem_wr_data      (m_wdata),
    .mem_byte_en      (m_be),
    .mem_rd_data      (m_rdata)
  );

  rv_mem_arbiter #(
    .MEM_SIZE_WORDS (256),
    .STARVE_LIMIT   (1)
  ) dut1 (
    .clk              (clk),
    .rst              (rst),
    .if_req_Q100H     (if_req),
    .if_addr_Q100H    (if_addr),
    .if_gnt_Q100H     (g1_if),
    .if_rvalid_Q101H  (rv1_if),
    .if_rdata_Q101H   (rd1_if),
    .dm_req_Q103H     (dm_req),
    .dm_addr_Q103H    (dm_addr),
    .dm_wr_en_Q103H   (dm_wr),
    .dm_wr_data_Q103H (dm_wdata),
    .dm_byte_en_Q103H (dm_be),
    .dm_gnt_Q103H     (g1_dm),
    .dm_rvalid_Q104H  (rv1_dm),
    .dm_rdata_Q104H   (rd1_dm),
    .stall_if         (s1_if),
    .stall_mem        (s1_mem),
    .mem_addr         (m1_addr),
    .mem_wr_en        (m1_wr),
    .mem_wr_data      (m1_wdata),
    .mem_byte_en      (m1_be),
    .mem_rd_data      (zero32)
  );

  // single-port RAM model, 1-cycle read, byte-enabled write
  always @(posedge clk) begin
    if (load) begin
      for (int w = 0; w < 256; w++)
        ram[w] <= 32'hA000_0000 + 32'(w);
      ram[4]  <= 32'hDEAD_BEEF;
      ram[16] <= 32'hCAFE_F00D;
    end else if (m_wr) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b])
          ram[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end
    m_rdata <= ram[m_addr];
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic        dm_wr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_st_if;
    logic        e_st_mem;
    logic [7:0]  e_addr;
    logic        e_wr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_dm_rv;
    logic [31:0] e_dm_rd;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da,
                       input logic dw);
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_addr  = da;
    dm_wr    = dw;
    dm_wdata = dw ? 32'hFFFF_FFFF : 32'h0;
    dm_be    = dw ? 4'hF : 4'h0;
  endtask

  initial begin
    // if dm  dm_addr       wr wdata        be  | gi gd si sm addr wr wdata        be  ivr irdata      dvr drdata
    vt[0]  = '{0,32'h0,  0,32'h0,  0,32'h0,        4'h0, 0,0,0,0,8'd0, 0,32'h0,        4'h0, 0,32'h0,          0,32'h0};
    vt[1]  = '{1,32'h10, 0,32'h0,  0,32'h0,        4'h0, 1,0,0,0,8'd4, 0,32'h0,        4'h0, 0,32'h0,          0,32'h0};
    vt[2]  = '{0,32'h0,  0,32'h0,  0,32'h0,        4'h0, 0,0,0,0,8'd4, 0,32'h0,        4'h0, 1,32'hDEADBEEF,   0,32'h0};
    vt[3]  = '{0,32'h0,  1,32'h40, 1,32'h11223344, 4'h3, 0,1,0,0,8'd16,1,32'h11223344, 4'h3, 0,32'h0,          0,32'h0};
    vt[4]  = '{0,32'h0,  1,32'h40, 0,32'h0,        4'h0, 0,1,0,0,8'd16,0,32'h0,        4'h0, 0,32'h0,          0,32'h0};
    vt[5]  = '{0,32'h0,  0,32'h0,  0,32'h0,        4'h0, 0,0,0,0,8'd16,0,32'h0,        4'h0, 0,32'h0,          1,32'hCAFE3344};
    vt[6]  = '{0,32'h0,  1,32'h44, 0,32'h0,        4'h0, 0,1,0,0,8'd17,0,32'h0,        4'h0, 0,32'h0,          0,32'h0};
    vt[7]  = '{1,32'h8,  0,32'h0,  0,32'h0,        4'h0, 1,0,0,0,8'd2, 0,32'h0,        4'h0, 0,32'h0,          1,32'hA0000011};
    vt[8]  = '{0,32'h0,  1,32'h48, 0,32'h0,        4'h0, 0,1,0,0,8'd18,0,32'h0,        4'h0, 1,32'hA0000002,   0,32'h0};
    vt[9]  = '{1,32'hC,  0,32'h0,  0,32'h0,        4'h0, 1,0,0,0,8'd3, 0,32'h0,        4'h0, 0,32'h0,          1,32'hA0000012};
    vt[10] = '{0,32'h0,  0,32'h0,  0,32'h0,        4'h0, 0,0,0,0,8'd3, 0,32'h0,        4'h0, 1,32'hA0000003,   0,32'h0};
    vt[11] = '{1,32'h400,0,32'h0,  0,32'h0,        4'h0, 1,0,0,0,8'd0, 0,32'h0,        4'h0, 0,32'h0,          0,32'h0};
    vt[12] = '{0,32'h0,  1,32'h404,0,32'h0,        4'h0, 0,1,0,0,8'd1, 0,32'h0,        4'h0, 1,32'hA0000000,   0,32'h0};
    vt[13] = '{0,32'h0,  0,32'h0,  0,32'h0,        4'h0, 0,0,0,0,8'd1, 0,32'h0,        4'h0, 0,32'h0,          1,32'hA0000001};
    vt[14] = '{1,32'h0,  1,32'h8,  1,32'hFFFFFFFF, 4'hF, 0,1,1,0,8'd2, 1,32'hFFFFFFFF, 4'hF, 0,32'h0,          0,32'h0};
    vt[15] = '{1,32'h8,  0,32'h0,  0,32'h0,        4'h0, 1,0,0,0,8'd2, 0,32'h0,        4'h0, 0,32'h0,          0,32'h0};
    vt[16] = '{0,32'h0,  0,32'h0,  0,32'h0,        4'h0, 0,0,0,0,8'd2, 0,32'h0,        4'h0, 1,32'hFFFFFFFF,   0,32'h0};

    rst  = 1'b1;
    load = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0);
    step();
    step();
    rst  = 1'b0;
    load = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if_req   = vt[i].if_req;
      if_addr  = vt[i].if_addr;
      dm_req   = vt[i].dm_req;
      dm_addr  = vt[i].dm_addr;
      dm_wr    = vt[i].dm_wr;
      dm_wdata = vt[i].dm_wdata;
      dm_be    = vt[i].dm_be;
      #1;
      chk($sformatf("v%0d if_gnt", i), 32'(if_gnt), 32'(vt[i].e_if_gnt));
      chk($sformatf("v%0d dm_gnt", i), 32'(dm_gnt), 32'(vt[i].e_dm_gnt));
      chk($sformatf("v%0d stall_if", i), 32'(st_if), 32'(vt[i].e_st_if));
      chk($sformatf("v%0d stall_mem", i), 32'(st_mem), 32'(vt[i].e_st_mem));
      chk($sformatf("v%0d mem_addr", i), 32'(m_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d mem_wr_en", i), 32'(m_wr), 32'(vt[i].e_wr));
      chk($sformatf("v%0d mem_wr_data", i), m_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d mem_byte_en", i), 32'(m_be), 32'(vt[i].e_be));
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rv), 32'(vt[i].e_if_rv));
      chk($sformatf("v%0d if_rdata", i), if_rd, vt[i].e_if_rd);
      chk($sformatf("v%0d dm_rvalid", i), 32'(dm_rv), 32'(vt[i].e_dm_rv));
      chk($sformatf("v%0d dm_rdata", i), dm_rd, vt[i].e_dm_rd);
      step();
    end

    // reset with live requests and a write: everything forced low
    rst = 1'b1;
    drive(1, 32'h20, 1, 32'h24, 1);
    #1;
    chk("rst if_gnt", 32'(if_gnt), 32'h0);
    chk("rst dm_gnt", 32'(dm_gnt), 32'h0);
    chk("rst stall_if", 32'(st_if), 32'h0);
    chk("rst stall_mem", 32'(st_mem), 32'h0);
    chk("rst mem_wr_en", 32'(m_wr), 32'h0);
    chk("rst dut1 gnt", 32'({g1_if, g1_dm}), 32'h0);
    step();
    rst = 1'b0;
    chk("post-rst ram[9]", ram[9], 32'hA000_0009);

    // continuous conflict: 4 data then 1 fetch; limit 1 alternates
    drive(1, 32'h20, 1, 32'h24, 0);
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("starve%0d dm_gnt", k), 32'(dm_gnt), 32'((k % 5) != 4));
      chk($sformatf("starve%0d if_gnt", k), 32'(if_gnt), 32'((k % 5) == 4));
      chk($sformatf("starve%0d stall_if", k), 32'(st_if), 32'((k % 5) != 4));
      chk($sformatf("starve%0d stall_mem", k), 32'(st_mem), 32'((k % 5) == 4));
      chk($sformatf("lim1_%0d if_gnt", k), 32'(g1_if), 32'((k % 2) == 1));
      chk($sformatf("lim1_%0d dm_gnt", k), 32'(g1_dm), 32'((k % 2) == 0));
      step();
    end

    // restart the conflict, then reset right after a granted data read
    rst = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0);
    step();
    rst = 1'b0;
    drive(1, 32'h0, 1, 32'h40, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pre%0d dm_gnt", k), 32'(dm_gnt), 32'h1);
      step();
    end
    rst = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0);
    #1;
    chk("midrst dm_rvalid", 32'(dm_rv), 32'h0);
    chk("midrst dm_rdata", dm_rd, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("after dm_rvalid", 32'(dm_rv), 32'h0);
    chk("after if_rvalid", 32'(if_rv), 32'h0);
    chk("after dm_rdata", dm_rd, 32'h0);
    drive(1, 32'h0, 1, 32'h40, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("clr%0d dm_gnt", k), 32'(dm_gnt), 32'(k != 4));
      chk($sformatf("clr%0d if_gnt", k), 32'(if_gnt), 32'(k == 4));
      step();
    end
    drive(0, 32'h0, 0, 32'h0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between the instruction-fetch requester (Q100H) and the data-access requester (Q103H).
- Grants one request per cycle. Data has fixed priority, with a starvation guard so fetch always makes progress.
- Returns read data to the owning requester one cycle after grant, tagged valid.
- Produces per-requester stall signals for the pipeline hazard logic.
- Sits between the core pipeline and the shared memory instance, in place of the split instruction/data memory arrangement.

Parameters:
- MEM_SIZE_WORDS, 256, depth of the shared RAM in 32-bit words; sets the word-address width.
- STARVE_LIMIT, 4, maximum consecutive cycles a pending fetch may lose arbitration. Legal range 1..15.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- if_req_Q100H  in  1  fetch request
- if_addr_Q100H  in  32  fetch byte address; bits [1:0] ignored
- if_gnt_Q100H  out  1  fetch granted this cycle
- if_rvalid_Q101H  out  1  fetch read data valid
- if_rdata_Q101H  out  32  fetch read data
- dm_req_Q103H  in  1  data request
- dm_addr_Q103H  in  32  data byte address; bits [1:0] ignored
- dm_wr_en_Q103H  in  1  1 = write, 0 = read
- dm_wr_data_Q103H  in  32  write data, already lane-aligned
- dm_byte_en_Q103H  in  4  write byte enables
- dm_gnt_Q103H  out  1  data granted this cycle
- dm_rvalid_Q104H  out  1  data read data valid
- dm_rdata_Q104H  out  32  data read data
- stall_if  out  1  fetch requested but not granted
- stall_mem  out  1  data requested but not granted
- mem_addr  out  log2(MEM_SIZE_WORDS)  RAM word address
- mem_wr_en  out  1  RAM write strobe
- mem_wr_data  out  32  RAM write data
- mem_byte_en  out  4  RAM byte enables
- mem_rd_data  in  32  RAM read data, valid one cycle after address

Behaviour:
- Arbitration is combinational within the cycle; the grant decision uses registered state only.
- Owner FSM has two states:
  - DPRI (reset state): data wins a conflict.
  - FORCE_I: fetch wins a conflict.
- Starvation counter starve_cnt is 4 bits, reset to 0.
  - +1 when if_req is asserted but not granted.
  - Cleared to 0 when fetch is granted or if_req=0.
  - Saturates at STARVE_LIMIT.
- FSM transitions:
  - DPRI -> FORCE_I when the next-state starve_cnt equals STARVE_LIMIT.
  - FORCE_I -> DPRI when fetch is granted or if_req drops.
- Grant rules (exactly one grant per cycle when any request is present):
  - Only one requester active: that requester is granted.
  - Both active in DPRI: dm_gnt=1.
  - Both active in FORCE_I: if_gnt=1.
  - No requests: no grant, mem_wr_en=0, mem_addr holds its last value.
- Memory drive:
  - Granted address bits [log2(MEM_SIZE_WORDS)+1:2] go to mem_addr. Upper bits are truncated, so addresses wrap modulo the RAM size.
  - mem_wr_en = dm_gnt & dm_wr_en. Byte enables and write data pass through only on a data write; otherwise they are 0.
  - A fetch is always a read.
- Read return:
  - A 2-bit registered tag {rd_if, rd_dm} records which requester's read was issued.
  - Next cycle, the matching rvalid is 1 and rdata = mem_rd_data. The non-owner rdata is 0.
  - A data write sets no tag and produces no rvalid.
- Stalls:
  - stall_if = if_req & ~if_gnt.
  - stall_mem = dm_req & ~dm_gnt.
  - Both are combinational. Requesters must hold address and data stable while stalled.
- Back-to-back: a new grant every cycle is allowed; read tags pipeline independently.
- Reset values: FSM=DPRI, starve_cnt=0, both tags=0. Therefore if_rvalid=dm_rvalid=0 and both rdata=0 in the cycle after reset. While rst=1, grants, stalls and mem_wr_en are forced to 0.
- Reset mid-operation: an in-flight read tag is cleared, so no rvalid appears after reset. A write granted in the same cycle rst is high is suppressed.
- STARVE_LIMIT=1: fetch wins every second conflicting cycle.

Decomposition:
- Package rv_mem_arb_pkg holds:
  - owner FSM enum t_arb_state {DPRI, FORCE_I}
  - t_rd_tag struct {rd_if, rd_dm}
  - STARVE_CNT_W=4 constant
- One natural sub-module: rv_mem_arb_starve, containing the starvation counter and FSM, which outputs force_if.
- The datapath muxing and read-return tags stay in the top module.
- State registers use the shared DFF macros with synchronous reset.

Test Plan:
- Single fetch to 0x0000_0010 (RAM word4=0xDEADBEEF) -> if_gnt=1 at cycle N; if_rvalid=1 with if_rdata=0xDEADBEEF at N+1; no dm_rvalid.
- Data write 0x0000_0040, data=0x11223344, byte_en=4'b0011, then a data read of the same address -> mem_wr_en for one cycle; the read returns 0xXXXX3344 on dm_rdata at the next cycle, with the upper lanes unchanged.
- Both requesting continuously, STARVE_LIMIT=4 -> dm_gnt for 4 cycles with stall_if=1, then if_gnt for 1 cycle with stall_mem=1; the pattern repeats every 5 cycles.
- Alternating data read / fetch read every cycle -> rvalid tags alternate correctly, with no cross-delivery of rdata.
- rst asserted the cycle after a granted data read -> dm_rvalid stays 0, FSM returns to DPRI, starve_cnt=0.
- Address 0x0000_0400 with MEM_SIZE_WORDS=256 -> wraps to mem_addr=0.
